sd_spi_arbiter: RTL and testbench
=================================

Name: sd_spi_arbiter

Overview:
- Shares one SD-card SPI port between two requesters, e.g. a CPU port interface (requester 0) and a TR-DOS emulation engine (requester 1).
- Arbitrates bus ownership, drives chip select and performs mode-0 byte transfers: MSB first, sdclk idles low, master samples on the rising edge, card shifts on the falling edge.
- Sits between the requesters and the SD pins; in the contention bench it connects directly to the SD card emulator.

Parameters:
DIV, 2, sdclk half-period in clk cycles (legal range 1..255)
GAP, 2, minimum clk cycles sdcs_n stays high between owners (legal range 1..255)

Ports:
clk  in  1  system clock; all logic on its rising edge
rst  in  1  synchronous reset, active-high
sdcs_n  out  1  SD chip select, active low
sdclk  out  1  SPI clock to card
sddo  out  1  master data out (card DI)
sddi  in  1  master data in (card DO)
sel  in  2  sel[i]=1: requester i wants ownership (level)
start  in  2  start[i]: one-cycle request for a byte transfer
wrdata0  in  8  byte to send for requester 0
wrdata1  in  8  byte to send for requester 1
grant  out  2  one-hot; current owner, or 0 if none
done  out  2  done[i]: one-cycle pulse, owner i's byte complete
rddata  out  8  last received byte; held until the next done

Behaviour:
- Reset values: sdcs_n=1, sdclk=0, sddo=1, grant=0, done=0, rddata=0x00, last_owner=1, FSM in FREE.
- rst is synchronous and overrides everything, including a transfer in progress. Outputs take reset values on the clk edge at which rst is sampled high. No done is issued for an aborted transfer.
- Ownership FSM states: FREE, OWNED, GAPWAIT.
  - FREE: if any sel bit is high, grant the requester on the next cycle.
  - Both sel bits high: grant the requester != last_owner (round-robin). Set last_owner to the grantee.
  - sdcs_n = ~(grant!=0), registered with grant; it falls in the same cycle grant rises.
- OWNED -> GAPWAIT when sel[owner]=0 and no transfer is active.
  - If sel[owner] drops mid-transfer, the byte completes, done pulses, then release happens on the following cycle.
  - On release: grant=0 and sdcs_n=1.
- GAPWAIT holds for GAP cycles, then returns to FREE. This guarantees a cs_n rising edge, so the card reloads its shifter on the next falling edge.
- Transfer FSM states: IDLE, SHIFT.
  - Accept start[i] only in IDLE with grant[i]=1. Starts from a non-owner, or any start during SHIFT, are ignored silently, with no done.
  - Start sampled at cycle t: latch wrdata_i into the TX shifter.
  - Cycle t+1: sddo = bit7.
  - Then 8 bit periods, each DIV cycles sdclk=0 followed by DIV cycles sdclk=1.
  - On each sdclk rising transition, shift sddi into the RX shifter (LSB in).
  - On each falling transition except the last, shift TX left; sddo = new bit7.
  - After the 8th falling transition: rddata = RX, done[owner]=1 for one cycle, state IDLE, sddo=1.
- Latency: done is asserted at cycle t+1+16*DIV (t+33 for DIV=2).
- A new start is accepted in the done cycle itself, which gives back-to-back bytes.
- sdclk only toggles in SHIFT, so the card sees exactly 8 falling edges per byte.
- Half-period counter: 8 bits; it reloads DIV-1 on every sdclk phase change; the bit counter is 3 bits.
- Outside SHIFT, sddo=1 (idle high, as SD requires).

Test Plan:
- Reset: hold rst 3 cycles mid-stream -> sdcs_n=1, sdclk=0, sddo=1, grant=00, done=00, rddata=0x00 on the next cycle.
- Requester 0 alone with the emulator: sel=01, start[0] with wrdata0=0xA5, then 0x3C back-to-back.
  - grant=01 and sdcs_n=0 one cycle after sel.
  - sddo bit sequence 10100101 then 00111100.
  - rddata=0x00 then 0x01; done[0] at t+33.
- Simultaneous sel=11 out of reset -> grant=01 first.
  - Drop sel[0] -> grant=00 with sdcs_n=1 for >=2 cycles, then grant=10.
  - The emulator resyncs: requester 1's first byte equals the emulator's current counter value.
- start[1] pulsed while requester 0 owns -> no sdclk toggles, done=00, rddata unchanged.
- sel[0] dropped at bit 3 of a transfer -> all 8 sdclk pulses complete, done[0] pulses, release the next cycle.
- start[0] held high for 40 cycles (DIV=2) -> only the starts in IDLE are taken: bytes accepted at t and at t+33, no extra done.

Source files
------------

// File: rtl/sd_spi_arbiter.sv
// Two-requester SD-card SPI arbiter: round-robin ownership with a chip-select gap
// between owners, plus a mode-0 (MSB first, sample on rise) byte shifter.
module sd_spi_arbiter #(
  parameter int unsigned DIV = 2,
  parameter int unsigned GAP = 2
) (
  input  logic       clk,
  input  logic       rst,
  output logic       sdcs_n,
  output logic       sdclk,
  output logic       sddo,
  input  logic       sddi,
  input  logic [1:0] sel,
  input  logic [1:0] start,
  input  logic [7:0] wrdata0,
  input  logic [7:0] wrdata1,
  output logic [1:0] grant,
  output logic [1:0] done,
  output logic [7:0] rddata
);

  localparam logic [1:0] StFree    = 2'd0;
  localparam logic [1:0] StOwned   = 2'd1;
  localparam logic [1:0] StGapWait = 2'd2;

  localparam logic XfIdle  = 1'b0;
  localparam logic XfShift = 1'b1;

  localparam logic [7:0] HalfReload = 8'(DIV - 1);
  localparam logic [7:0] GapReload  = 8'(GAP - 1);

  logic [1:0] own_q, own_d;
  logic [1:0] grant_q, grant_d;
  logic       last_q, last_d;
  logic [7:0] gap_q, gap_d;
  logic       cs_n_q, cs_n_d;

  logic       xf_q, xf_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] half_q, half_d;
  logic [2:0] bit_q, bit_d;
  logic       sdclk_q, sdclk_d;
  logic [1:0] done_q, done_d;
  logic [7:0] rddata_q, rddata_d;

  logic owner;
  logic release_own;
  logic accept;

  assign owner       = grant_q[1];
  assign release_own = (own_q == StOwned) && !sel[owner] && (xf_q == XfIdle);
  // A start from an owner that is dropping sel in the same cycle would run with cs_n high.
  assign accept      = (xf_q == XfIdle) && ((start & grant_q & sel) != 2'b00);

  always_comb begin
    own_d   = own_q;
    grant_d = grant_q;
    last_d  = last_q;
    gap_d   = gap_q;
    case (own_q)
      StFree: begin
        if (sel != 2'b00) begin
          own_d = StOwned;
          if (sel == 2'b11) begin
            grant_d = last_q ? 2'b01 : 2'b10;
            last_d  = ~last_q;
          end else begin
            grant_d = sel;
            last_d  = sel[1];
          end
        end
      end
      StOwned: begin
        if (release_own) begin
          own_d   = StGapWait;
          grant_d = 2'b00;
          gap_d   = GapReload;
        end
      end
      StGapWait: begin
        if (gap_q == 8'd0) begin
          own_d = StFree;
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end
      default: begin
        own_d   = StFree;
        grant_d = 2'b00;
      end
    endcase
    cs_n_d = (grant_d == 2'b00);
  end

  always_comb begin
    xf_d     = xf_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    half_d   = half_q;
    bit_d    = bit_q;
    sdclk_d  = sdclk_q;
    done_d   = 2'b00;
    rddata_d = rddata_q;
    if (xf_q == XfIdle) begin
      if (accept) begin
        xf_d    = XfShift;
        tx_d    = grant_q[1] ? wrdata1 : wrdata0;
        half_d  = HalfReload;
        bit_d   = 3'd0;
        sdclk_d = 1'b0;
      end
    end else begin
      if (half_q == 8'd0) begin
        half_d  = HalfReload;
        sdclk_d = ~sdclk_q;
        if (!sdclk_q) begin
          rx_d = {rx_q[6:0], sddi};
        end else if (bit_q == 3'd7) begin
          // Eighth falling edge: byte complete; owner cannot change while shifting.
          xf_d     = XfIdle;
          rddata_d = rx_q;
          done_d   = grant_q;
        end else begin
          tx_d  = {tx_q[6:0], 1'b0};
          bit_d = bit_q + 3'd1;
        end
      end else begin
        half_d = half_q - 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      own_q    <= StFree;
      grant_q  <= 2'b00;
      last_q   <= 1'b1;
      gap_q    <= 8'd0;
      cs_n_q   <= 1'b1;
      xf_q     <= XfIdle;
      tx_q     <= 8'h00;
      rx_q     <= 8'h00;
      half_q   <= 8'd0;
      bit_q    <= 3'd0;
      sdclk_q  <= 1'b0;
      done_q   <= 2'b00;
      rddata_q <= 8'h00;
    end else begin
      own_q    <= own_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      gap_q    <= gap_d;
      cs_n_q   <= cs_n_d;
      xf_q     <= xf_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      half_q   <= half_d;
      bit_q    <= bit_d;
      sdclk_q  <= sdclk_d;
      done_q   <= done_d;
      rddata_q <= rddata_d;
    end
  end

  assign sdcs_n = cs_n_q;
  assign sdclk  = sdclk_q;
  assign sddo   = (xf_q == XfShift) ? tx_q[7] : 1'b1;
  assign grant  = grant_q;
  assign done   = done_q;
  assign rddata = rddata_q;

endmodule

// File: tb/tb_sd_spi_arbiter.sv
// Bench for sd_spi_arbiter with a counting SD-card emulator on the SPI pins:
// each byte the card returns is its byte counter, reloaded on every cs_n rise.
module tb_sd_spi_arbiter;

  localparam int unsigned DIV = 2;
  localparam int unsigned GAP = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       sdcs_n;
  logic       sdclk;
  logic       sddo;
  logic       sddi;
  logic [1:0] sel;
  logic [1:0] start;
  logic [7:0] wrdata0;
  logic [7:0] wrdata1;
  logic [1:0] grant;
  logic [1:0] done;
  logic [7:0] rddata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sd_spi_arbiter #(
    .DIV (DIV),
    .GAP (GAP)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .sdcs_n  (sdcs_n),
    .sdclk   (sdclk),
    .sddo    (sddo),
    .sddi    (sddi),
    .sel     (sel),
    .start   (start),
    .wrdata0 (wrdata0),
    .wrdata1 (wrdata1),
    .grant   (grant),
    .done    (done),
    .rddata  (rddata)
  );

  // Card emulator: shifts out its counter MSB first, advancing on falling sdclk.
  logic [7:0] emu_cnt  = 8'h00;
  logic [7:0] emu_sh   = 8'h00;
  int         emu_bits = 0;

  assign sddi = emu_sh[7];

  always @(negedge sdclk or posedge sdcs_n) begin
    if (sdcs_n !== 1'b0) begin
      emu_sh   = emu_cnt;
      emu_bits = 0;
    end else if (emu_bits == 7) begin
      emu_cnt  = emu_cnt + 8'h01;
      emu_sh   = emu_cnt;
      emu_bits = 0;
    end else begin
      emu_sh   = {emu_sh[6:0], 1'b0};
      emu_bits = emu_bits + 1;
    end
  end

  typedef struct {
    logic [1:0] sel;
    logic [1:0] start;
    logic [1:0] grant;
    logic       cs_n;
    logic       sclk;
    logic       dout;
    logic [1:0] dn;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_sdcs_n"}, 32'(sdcs_n), 32'd1);
    chk({tag, "_sdclk"},  32'(sdclk),  32'd0);
    chk({tag, "_sddo"},   32'(sddo),   32'd1);
    chk({tag, "_grant"},  32'(grant),  32'd0);
    chk({tag, "_done"},   32'(done),   32'd0);
    chk({tag, "_rddata"}, 32'(rddata), 32'h00);
  endtask

  task automatic wait_grant(input logic [1:0] exp, input string tag);
    for (int k = 0; k < 20 && grant !== exp; k++) tick;
    chk({tag, "_grant"}, 32'(grant), 32'(exp));
    chk({tag, "_sdcs_n"}, 32'(sdcs_n), 32'd0);
  endtask

  // Starts one byte for requester req and returns in the cycle done is seen.
  task automatic xfer(input int req, input logic [7:0] wd, input logic [7:0] exp_rd,
                      input int drop_after, input string tag);
    logic [7:0] bits;
    logic       prev_clk;
    int         rises;
    int         lat;
    bits  = 8'h00;
    rises = 0;
    lat   = 0;
    if (req == 0) wrdata0 = wd;
    else          wrdata1 = wd;
    start = (req == 0) ? 2'b01 : 2'b10;
    tick;
    start = 2'b00;
    chk({tag, "_sddo_msb"}, 32'(sddo), 32'(wd[7]));
    prev_clk = sdclk;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      tick;
      if (sdclk && !prev_clk) begin
        bits  = {bits[6:0], sddo};
        rises = rises + 1;
        if (rises == drop_after) sel[req] = 1'b0;
      end
      prev_clk = sdclk;
      if (done != 2'b00) lat = k;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(16 * DIV));
    chk({tag, "_done"}, 32'(done), (req == 0) ? 32'd1 : 32'd2);
    chk({tag, "_txbits"}, 32'(bits), 32'(wd));
    chk({tag, "_sclk_rises"}, 32'(rises), 32'd8);
    chk({tag, "_rddata"}, 32'(rddata), 32'(exp_rd));
    chk({tag, "_sddo_idle"}, 32'(sddo), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int         d_cnt;
    int         d_pos0;
    int         d_pos1;
    logic [7:0] rd0;
    logic [7:0] rd1;

    //            sel    start  grant  cs_n  sclk  sddo  done
    vecs[0] = '{2'b11, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1, 2'b00};
    vecs[1] = '{2'b11, 2'b10, 2'b01, 1'b0, 1'b0, 1'b1, 2'b00};
    vecs[2] = '{2'b11, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1, 2'b00};
    vecs[3] = '{2'b11, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1, 2'b00};
    vecs[4] = '{2'b10, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 2'b00};
    vecs[5] = '{2'b10, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 2'b00};
    vecs[6] = '{2'b10, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 2'b00};
    vecs[7] = '{2'b10, 2'b00, 2'b10, 1'b0, 1'b0, 1'b1, 2'b00};
    vecs[8] = '{2'b10, 2'b00, 2'b10, 1'b0, 1'b0, 1'b1, 2'b00};

    rst     = 1'b1;
    sel     = 2'b00;
    start   = 2'b00;
    wrdata0 = 8'h00;
    wrdata1 = 8'h00;
    repeat (3) tick;
    check_reset("por");
    rst = 1'b0;
    tick;
    check_reset("por_idle");

    // Requester 0 alone, two back-to-back bytes.
    sel = 2'b01;
    tick;
    chk("r0_grant", 32'(grant), 32'd1);
    chk("r0_sdcs_n", 32'(sdcs_n), 32'd0);
    xfer(0, 8'hA5, 8'h00, 0, "r0_b0");
    xfer(0, 8'h3C, 8'h01, 0, "r0_b1");
    tick;
    chk("r0_done_one_cycle", 32'(done), 32'd0);

    // Reset in the middle of a byte.
    wrdata0 = 8'hFF;
    start   = 2'b01;
    tick;
    start = 2'b00;
    repeat (10) tick;
    rst = 1'b1;
    tick;
    check_reset("rst_hit");
    tick;
    tick;
    check_reset("rst_hold");
    sel = 2'b00;
    rst = 1'b0;
    tick;
    check_reset("rst_after");

    // Contention, ignored foreign start, release gap, handover.
    for (int i = 0; i < NV; i++) begin
      sel   = vecs[i].sel;
      start = vecs[i].start;
      tick;
      chk($sformatf("vec%0d_grant", i),  32'(grant),  32'(vecs[i].grant));
      chk($sformatf("vec%0d_sdcs_n", i), 32'(sdcs_n), 32'(vecs[i].cs_n));
      chk($sformatf("vec%0d_sdclk", i),  32'(sdclk),  32'(vecs[i].sclk));
      chk($sformatf("vec%0d_sddo", i),   32'(sddo),   32'(vecs[i].dout));
      chk($sformatf("vec%0d_done", i),   32'(done),   32'(vecs[i].dn));
      chk($sformatf("vec%0d_rddata", i), 32'(rddata), 32'h00);
    end
    start = 2'b00;

    // Card was resynced by cs_n rises: its counter now reads 2.
    xfer(1, 8'h5A, 8'h02, 0, "r1_resync");

    // Owner drops sel mid-byte: byte completes, release follows the done cycle.
    sel = 2'b01;
    wait_grant(2'b01, "drop_pre");
    xfer(0, 8'hC3, 8'h03, 4, "drop");
    chk("drop_grant_in_done", 32'(grant), 32'd1);
    tick;
    chk("drop_release_grant", 32'(grant), 32'd0);
    chk("drop_release_sdcs_n", 32'(sdcs_n), 32'd1);
    chk("drop_release_done", 32'(done), 32'd0);

    // start[0] held for 40 cycles: only IDLE-cycle starts are taken.
    sel = 2'b01;
    wait_grant(2'b01, "hold_pre");
    wrdata0 = 8'h81;
    start   = 2'b01;
    d_cnt   = 0;
    d_pos0  = -1;
    d_pos1  = -1;
    rd0     = 8'h00;
    rd1     = 8'h00;
    for (int i = 0; i < 80; i++) begin
      tick;
      if (i == 39) start = 2'b00;
      if (done != 2'b00) begin
        if (d_cnt == 0) begin
          d_pos0 = i;
          rd0    = rddata;
          chk("hold_done_owner", 32'(done), 32'd1);
        end else if (d_cnt == 1) begin
          d_pos1 = i;
          rd1    = rddata;
        end
        d_cnt = d_cnt + 1;
      end
    end
    chk("hold_done_count", 32'(d_cnt), 32'd2);
    chk("hold_done0_pos", 32'(d_pos0), 32'd32);
    chk("hold_done1_pos", 32'(d_pos1), 32'd65);
    chk("hold_rd0", 32'(rd0), 32'h04);
    chk("hold_rd1", 32'(rd1), 32'h05);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
